// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: reset sequencer placed in front of the design top.
// It takes one board-level async reset and a software soft-reset request.
// It drives NUM_STAGES reset outputs that assert together and release one
// at a time, stage 0 first. It also reports status and counts soft resets.
//
// Ports:
//   i_clk           clock
//   i_async_rst     asynchronous reset, active-high
//   i_soft_rst_req  soft-reset request (level); only sampled in RUN
//   o_sync_rst      staged resets, active-high, release synchronous to i_clk
//   o_busy          1 whenever the sequencer is not in RUN
//   o_all_released  1 in RUN, when every o_sync_rst bit is low
//   o_soft_rst_cnt  number of accepted soft resets, saturating
module rst_seq_ctrl #(
    parameter int NUM_STAGES       = 2,
    parameter int SYNC_FF_STAGES   = 2,
    parameter int RST_HOLD_CYCLES  = 2,
    parameter int STAGE_GAP_CYCLES = 4,
    parameter int SOFT_HOLD_CYCLES = 8,
    parameter int CNT_W            = 8
) (
    input  logic                  i_clk,
    input  logic                  i_async_rst,
    input  logic                  i_soft_rst_req,
    output logic [NUM_STAGES-1:0] o_sync_rst,
    output logic                  o_busy,
    output logic                  o_all_released,
    output logic [CNT_W-1:0]      o_soft_rst_cnt
);

    localparam int MAX_A = (RST_HOLD_CYCLES > STAGE_GAP_CYCLES) ?
                           RST_HOLD_CYCLES : STAGE_GAP_CYCLES;
    localparam int MAX_T = (MAX_A > SOFT_HOLD_CYCLES) ?
                           MAX_A : SOFT_HOLD_CYCLES;
    localparam int TW    = $clog2(MAX_T + 1);
    localparam int SW    = SYNC_FF_STAGES - 1;

    localparam logic [TW-1:0] HOLD_LAST = TW'(RST_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(STAGE_GAP_CYCLES - 1);
    localparam logic [TW-1:0] SOFT_LAST = TW'(SOFT_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_SYNC,
        S_HOLD,
        S_RELEASE,
        S_RUN,
        S_SOFT_HOLD
    } state_t;

    // The release synchronizer is SYNC_FF_STAGES deep. The first
    // SYNC_FF_STAGES-1 flops form the chain below. The state register acts
    // as the final stage: it leaves SYNC on the same edge on which a
    // standalone chain output would go low.
    logic [SW-1:0]         r_sync;
    logic                  w_sync_rel;

    state_t                r_state;
    logic [TW-1:0]         r_tmr;
    logic [TW-1:0]         w_tmr_last;
    logic [NUM_STAGES-1:0] r_rst;
    logic [NUM_STAGES-1:0] w_rst_next;
    logic                  w_last_drop;
    logic                  r_busy;
    logic                  r_all;
    logic [CNT_W-1:0]      r_cnt;

    always_ff @(posedge i_clk or posedge i_async_rst) begin
        if (i_async_rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= r_sync << 1;
        end
    end

    assign w_sync_rel = ~r_sync[SW-1];

    // Stages release in order from bit 0 upward. Shifting a zero in at
    // the LSB drops the next stage, and once the vector is all zero the
    // last stage has gone.
    assign w_rst_next  = r_rst << 1;
    assign w_last_drop = (w_rst_next == '0);

    always_comb begin
        w_tmr_last = GAP_LAST;
        case (r_state)
            S_HOLD:      w_tmr_last = HOLD_LAST;
            S_SOFT_HOLD: w_tmr_last = SOFT_LAST;
            default:     w_tmr_last = GAP_LAST;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_async_rst) begin
        if (i_async_rst) begin
            r_state <= S_SYNC;
            r_tmr   <= '0;
            r_rst   <= '1;
            r_busy  <= 1'b1;
            r_all   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_SYNC: begin
                    if (w_sync_rel) begin
                        r_state <= S_HOLD;
                        r_tmr   <= '0;
                    end
                end
                S_HOLD, S_RELEASE, S_SOFT_HOLD: begin
                    if (r_tmr == w_tmr_last) begin
                        r_rst <= w_rst_next;
                        r_tmr <= '0;
                        if (w_last_drop) begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b0;
                            r_all   <= 1'b1;
                        end else begin
                            r_state <= S_RELEASE;
                        end
                    end else begin
                        r_tmr <= r_tmr + TW'(1);
                    end
                end
                S_RUN: begin
                    if (i_soft_rst_req) begin
                        r_rst   <= '1;
                        r_tmr   <= '0;
                        r_state <= S_SOFT_HOLD;
                        r_busy  <= 1'b1;
                        r_all   <= 1'b0;
                        if (r_cnt != '1) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_SYNC;
                end
            endcase
        end
    end

    assign o_sync_rst     = r_rst;
    assign o_busy         = r_busy;
    assign o_all_released = r_all;
    assign o_soft_rst_cnt = r_cnt;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed scoreboard bench for rst_seq_ctrl.
// It runs a default two-stage instance and a single-stage instance that share one reset.
module tb_rst_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       req;
    logic       breq;
    logic [1:0] a_rst;
    logic       a_busy;
    logic       a_all;
    logic [7:0] a_cnt;
    logic [0:0] b_rst;
    logic       b_busy;
    logic       b_all;
    logic [7:0] b_cnt;

    rst_seq_ctrl u_dut (
        .i_clk          (clk),
        .i_async_rst    (rst),
        .i_soft_rst_req (req),
        .o_sync_rst     (a_rst),
        .o_busy         (a_busy),
        .o_all_released (a_all),
        .o_soft_rst_cnt (a_cnt)
    );

    rst_seq_ctrl #(.NUM_STAGES(1)) u_dut1 (
        .i_clk          (clk),
        .i_async_rst    (rst),
        .i_soft_rst_req (breq),
        .o_sync_rst     (b_rst),
        .o_busy         (b_busy),
        .o_all_released (b_all),
        .o_soft_rst_cnt (b_cnt)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    typedef struct {
        int         e;
        string      tag;
        logic [1:0] rst;
        logic       busy;
        logic       all;
        logic [7:0] cnt;
        logic       chk_b;
        logic       brst;
        logic       ball;
    } exp_t;

    exp_t q[$];
    int   ecnt;
    int   nvec;
    int   nmis;

    task automatic push(int e, string tag, logic [1:0] r, logic b,
                        logic a, logic [7:0] c, logic cb,
                        logic br, logic ba);
        exp_t x;
        x.e = e; x.tag = tag; x.rst = r; x.busy = b; x.all = a;
        x.cnt = c; x.chk_b = cb; x.brst = br; x.ball = ba;
        q.push_back(x);
    endtask

    task automatic exp_a(int e, string tag, logic [1:0] r, logic b,
                         logic a, logic [7:0] c);
        push(e, tag, r, b, a, c, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic exp_ab(int e, string tag, logic [1:0] r, logic b,
                          logic a, logic [7:0] c, logic br, logic ba);
        push(e, tag, r, b, a, c, 1'b1, br, ba);
    endtask

    task automatic check_due();
        exp_t x;
        logic [11:0] obs;
        logic [11:0] exv;
        while (q.size() > 0 && q[0].e <= ecnt) begin
            x = q.pop_front();
            nvec++;
            assert (x.e == ecnt) else begin
                nmis++;
                $error("FAIL %s stale: edge %0d expected %0d",
                       x.tag, ecnt, x.e);
            end
            obs = {a_rst, a_busy, a_all, a_cnt};
            exv = {x.rst, x.busy, x.all, x.cnt};
            nvec++;
            assert (obs === exv) else begin
                nmis++;
                $error("FAIL %s: rst/busy/all/cnt got %b/%b/%b/%0d want %b/%b/%b/%0d",
                       x.tag, a_rst, a_busy, a_all, a_cnt,
                       x.rst, x.busy, x.all, x.cnt);
            end
            if (x.chk_b) begin
                nvec++;
                assert ({b_rst, b_all} === {x.brst, x.ball}) else begin
                    nmis++;
                    $error("FAIL %s_1stage: rst/all got %b/%b want %b/%b",
                           x.tag, b_rst, b_all, x.brst, x.ball);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        ecnt++;
        #1;
        check_due();
    endtask

    task automatic run_to(int e);
        while (ecnt < e) tick();
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; breq = 1'b0;
        ecnt = 0; nvec = 0; nmis = 0;
        #2;
        exp_ab(ecnt, "rst_val", 2'b11, 1, 0, 0, 1, 0);
        check_due();
        #20;
        rst = 1'b0;
        ecnt = 0;
        // test 1 / test 6
        exp_ab(1, "t1_e1", 2'b11, 1, 0, 0, 1, 0);
        exp_ab(3, "t1_e3", 2'b11, 1, 0, 0, 1, 0);
        exp_ab(4, "t1_e4", 2'b10, 1, 0, 0, 0, 1);
        exp_a(7, "t1_e7", 2'b10, 1, 0, 0);
        exp_a(8, "t1_e8", 2'b00, 0, 1, 0);
        exp_a(9, "t1_e9", 2'b00, 0, 1, 0);
        run_to(9);
        // test 2 / test 3, accepted at edge 10
        req = 1'b1;
        exp_a(10, "t2_acc", 2'b11, 1, 0, 1);
        tick();
        req = 1'b0;
        exp_a(12, "t2_e12", 2'b11, 1, 0, 1);
        run_to(12);
        req = 1'b1;
        exp_a(13, "t3_ign1", 2'b11, 1, 0, 1);
        tick();
        req = 1'b0;
        exp_a(17, "t2_n7", 2'b11, 1, 0, 1);
        exp_a(18, "t2_b0", 2'b10, 1, 0, 1);
        run_to(19);
        req = 1'b1;
        exp_a(20, "t3_ign2", 2'b10, 1, 0, 1);
        tick();
        req = 1'b0;
        exp_a(21, "t2_n11", 2'b10, 1, 0, 1);
        exp_a(22, "t2_run", 2'b00, 0, 1, 1);
        exp_a(23, "t2_n13", 2'b00, 0, 1, 1);
        run_to(23);
        // test 4: reset from RUN clears count, then again mid-sequence
        rst = 1'b1;
        #1;
        exp_ab(ecnt, "t4_rst", 2'b11, 1, 0, 0, 1, 0);
        check_due();
        #2;
        rst = 1'b0;
        ecnt = 0;
        exp_ab(4, "t4a_e4", 2'b10, 1, 0, 0, 0, 1);
        exp_a(6, "t4a_e6", 2'b10, 1, 0, 0);
        run_to(6);
        rst = 1'b1;
        #1;
        exp_ab(ecnt, "t4_mid", 2'b11, 1, 0, 0, 1, 0);
        check_due();
        #2;
        rst = 1'b0;
        ecnt = 0;
        exp_ab(3, "t4_e3", 2'b11, 1, 0, 0, 1, 0);
        exp_ab(4, "t4_e4", 2'b10, 1, 0, 0, 0, 1);
        exp_a(7, "t4_e7", 2'b10, 1, 0, 0);
        exp_a(8, "t4_e8", 2'b00, 0, 1, 0);
        run_to(8);
        // test 5: request held high, one accept every 13 edges
        req = 1'b1;
        exp_a(9, "t5_first", 2'b11, 1, 0, 1);
        exp_a(21, "t5_run1", 2'b00, 0, 1, 1);
        exp_a(22, "t5_acc2", 2'b11, 1, 0, 2);
        exp_a(3310, "t5_254", 2'b00, 0, 1, 254);
        exp_a(3311, "t5_255", 2'b11, 1, 0, 255);
        exp_a(3895, "t5_satrun", 2'b00, 0, 1, 255);
        exp_a(3896, "t5_sat", 2'b11, 1, 0, 255);
        run_to(3896);
        req = 1'b0;
        exp_a(3904, "t5_b0", 2'b10, 1, 0, 255);
        exp_a(3908, "t5_end", 2'b00, 0, 1, 255);
        exp_a(3910, "t5_idle", 2'b00, 0, 1, 255);
        run_to(3910);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
